// File: rtl/irq_ctrl_pkg.sv
// Shared types for the interrupt controller: handshake state encoding.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StRequest   = 2'd1,
    StDeliver   = 2'd2,
    StInService = 2'd3
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set bit of I_req wins.
module irq_prio_enc #(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0]         I_req,
  output logic                       O_valid,
  output logic [$clog2(NUM_IRQ)-1:0] O_idx
);

  localparam int unsigned IdxW = $clog2(NUM_IRQ);

  always_comb begin
    O_valid = |I_req;
    O_idx   = '0;
    // Scan downwards so the lowest index is the last to assign.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (I_req[i]) begin
        O_idx = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched, masked, fixed-priority delivery with ack/EOI handshake.
// Define IRQ_CTRL_LEVEL_EN to add LEVEL_MASK for level-sensitive channels.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned VEC_W       = 16,
  parameter int unsigned VECTOR_BASE = 0
`ifdef IRQ_CTRL_LEVEL_EN
  ,
  parameter logic [NUM_IRQ-1:0] LEVEL_MASK = '0
`endif
) (
  input  logic               I_clk,
  input  logic               I_reset_n,
  input  logic [NUM_IRQ-1:0] I_irq,
  input  logic               I_irq_ack,
  input  logic               I_eoi,
  input  logic               I_mask_we,
  input  logic [NUM_IRQ-1:0] I_mask_data,
  output logic               O_irq_active,
  output logic [VEC_W-1:0]   O_irq_number,
  output logic               O_irq_number_valid,
  output logic [NUM_IRQ-1:0] O_pending,
  output logic               O_in_service
);

  localparam int unsigned IdxW = $clog2(NUM_IRQ);

  irq_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q;
  logic [VEC_W-1:0]   num_q, num_d;

  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic               any_eligible;
  logic [IdxW-1:0]    win_idx;

  assign eligible = pending_q & mask_q;
  assign rise     = I_irq & ~irq_prev_q;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .I_req   (eligible),
    .O_valid (any_eligible),
    .O_idx   (win_idx)
  );

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    clr     = '0;
    case (state_q)
      StIdle: begin
        if (any_eligible) state_d = StRequest;
      end
      StRequest: begin
        if (I_irq_ack) begin
          state_d = StDeliver;
          if (any_eligible) begin
            num_d = VEC_W'(VECTOR_BASE) + VEC_W'(win_idx);
            clr   = NUM_IRQ'(1) << win_idx;
          end else begin
            // Eligibility vanished under the ack: hand out the spurious vector.
            num_d = VEC_W'(VECTOR_BASE + NUM_IRQ);
          end
        end else if (!any_eligible) begin
          state_d = StIdle;
        end
      end
      StDeliver: state_d = StInService;
      StInService: begin
        if (I_eoi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Clear-by-ack beats a coincident new edge on the same channel.
    pending_d = (pending_q | rise) & ~clr;
`ifdef IRQ_CTRL_LEVEL_EN
    pending_d = (pending_d & ~LEVEL_MASK) | (I_irq & LEVEL_MASK);
`endif
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q    <= StIdle;
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      num_q      <= '0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= I_irq;
      pending_q  <= pending_d;
      num_q      <= num_d;
      if (I_mask_we) mask_q <= I_mask_data;
    end
  end

  assign O_irq_active       = (state_q == StRequest);
  assign O_irq_number_valid = (state_q == StDeliver);
  assign O_in_service       = (state_q == StInService);
  assign O_irq_number       = num_q;
  assign O_pending          = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl; delivered vectors are checked by a queue-based scoreboard.
module tb_irq_ctrl;

  localparam int unsigned NUM_IRQ     = 8;
  localparam int unsigned VEC_W       = 16;
  localparam int unsigned VECTOR_BASE = 0;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_IRQ-1:0] irq;
  logic               ack;
  logic               eoi;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_data;
  logic               irq_active;
  logic [VEC_W-1:0]   irq_number;
  logic               irq_number_valid;
  logic [NUM_IRQ-1:0] pending;
  logic               in_service;

  int n_vec = 0;
  int n_err = 0;
  logic [VEC_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  irq_ctrl #(
    .NUM_IRQ     (NUM_IRQ),
    .VEC_W       (VEC_W),
    .VECTOR_BASE (VECTOR_BASE)
  ) dut (
    .I_clk              (clk),
    .I_reset_n          (rst_n),
    .I_irq              (irq),
    .I_irq_ack          (ack),
    .I_eoi              (eoi),
    .I_mask_we          (mask_we),
    .I_mask_data        (mask_data),
    .O_irq_active       (irq_active),
    .O_irq_number       (irq_number),
    .O_irq_number_valid (irq_number_valid),
    .O_pending          (pending),
    .O_in_service       (in_service)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [NUM_IRQ-1:0] m);
    mask_we   = 1'b1;
    mask_data = m;
    tick();
    mask_we   = 1'b0;
  endtask

  // Must be called while in REQUEST; ends back in IDLE after EOI.
  task automatic serve(input logic [VEC_W-1:0] exp_vec);
    exp_q.push_back(exp_vec);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("deliver_active_low", 32'(irq_active), 32'd0);
    tick();
    check("in_service_after_deliver", 32'(in_service), 32'd1);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  // Monitor: every delivery pops one expected vector.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && irq_number_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_delivery: got vector %0d, expected none", irq_number);
      end else begin
        check("delivered_vector", 32'(irq_number), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    irq       = '0;
    ack       = 1'b0;
    eoi       = 1'b0;
    mask_we   = 1'b0;
    mask_data = '0;
    #22;
    check("rst_active", 32'(irq_active), 32'd0);
    check("rst_number", 32'(irq_number), 32'd0);
    check("rst_valid", 32'(irq_number_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_in_service", 32'(in_service), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single edge on channel 3.
    write_mask(8'hFF);
    irq = 8'h08;
    tick();
    check("ch3_pending", 32'(pending), 32'h08);
    check("ch3_active_1cyc", 32'(irq_active), 32'd0);
    tick();
    check("ch3_active_2cyc", 32'(irq_active), 32'd1);
    exp_q.push_back(16'd3);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ch3_valid", 32'(irq_number_valid), 32'd1);
    check("ch3_pending_cleared", 32'(pending), 32'h00);
    tick();
    check("ch3_valid_drop", 32'(irq_number_valid), 32'd0);
    check("ch3_number_hold", 32'(irq_number), 32'd3);
    check("ch3_in_service", 32'(in_service), 32'd1);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    irq = '0;
    tick();

    // Channels 5 and 2 together: 2 first, then 5 after EOI.
    irq = 8'h24;
    tick();
    tick();
    check("dual_active", 32'(irq_active), 32'd1);
    serve(16'd2);
    check("dual_pending_5", 32'(pending), 32'h20);
    tick();
    check("ch5_active", 32'(irq_active), 32'd1);
    serve(16'd5);
    irq = '0;
    tick();

    // Masked request released by a later mask write.
    write_mask(8'h00);
    irq = 8'h02;
    tick();
    check("masked_pending", 32'(pending), 32'h02);
    tick();
    check("masked_no_active", 32'(irq_active), 32'd0);
    write_mask(8'h02);
    check("unmask_same_cycle", 32'(irq_active), 32'd0);
    tick();
    check("unmask_active", 32'(irq_active), 32'd1);
    serve(16'd1);
    irq = '0;

    // Spurious: mask cleared while REQUEST for channel 4 is outstanding.
    write_mask(8'hFF);
    irq = 8'h10;
    tick();
    tick();
    check("ch4_active", 32'(irq_active), 32'd1);
    irq = '0;
    write_mask(8'h00);
    serve(16'd8);
    check("spurious_keeps_pending", 32'(pending), 32'h10);

    // Re-enable: channel 4 delivered, then edges and stray ack during service.
    write_mask(8'hFF);
    tick();
    check("ch4_rerequest", 32'(irq_active), 32'd1);
    exp_q.push_back(16'd4);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    irq = 8'h41;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    check("isr_no_active", 32'(irq_active), 32'd0);
    check("isr_in_service", 32'(in_service), 32'd1);
    check("isr_pending", 32'(pending), 32'h41);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    check("post_eoi_active", 32'(irq_active), 32'd1);
    exp_q.push_back(16'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Reset asserted mid-DELIVER, after the monitor has sampled it.
    #5;
    rst_n = 1'b0;
    #1;
    check("midrst_active", 32'(irq_active), 32'd0);
    check("midrst_valid", 32'(irq_number_valid), 32'd0);
    check("midrst_number", 32'(irq_number), 32'd0);
    check("midrst_pending", 32'(pending), 32'd0);
    check("midrst_in_service", 32'(in_service), 32'd0);
    irq = '0;
    #10;
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_active", 32'(irq_active), 32'd0);
    check("post_rst_pending", 32'(pending), 32'd0);
    check("all_delivered", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
